// File: rtl/fs_pkg.sv
// Shared defaults for the fragment shading path plus the channel-slice helper
// used wherever CH equal-width channels are packed side by side (ch0 in LSBs).
`ifndef FS_PKG_MACROS
`define FS_PKG_MACROS
`define FS_CH_SLICE(idx, w) ((idx) * (w)) +: (w)
`endif

package fs_pkg;
  localparam int IN_W_DEF = 20;
  localparam int Q_W_DEF  = 4;
  localparam int CH_DEF   = 3;
  localparam logic [CH_DEF*Q_W_DEF-1:0] BG_COLOR_DEF = 12'h137;
endpackage

// File: rtl/bary_div_stage.sv
// One restoring-division step for one channel: shifts the remainder, trial
// subtracts the denominator and appends the resolved quotient bit.
module bary_div_stage
  import fs_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int Q_W  = Q_W_DEF
) (
  input  logic [IN_W-1:0] rem,
  input  logic [IN_W-1:0] den,
  input  logic [Q_W-1:0]  q_in,
  output logic [IN_W-1:0] rem_out,
  output logic [Q_W-1:0]  q_out
);
  logic [IN_W:0]   trial;
  logic            q_bit;
  logic [IN_W-1:0] diff;
  logic            unused_q_msb;

  // rem < den on the quotient path, so the low IN_W bits of the difference are exact
  assign trial        = {rem, 1'b0};
  assign q_bit        = (trial >= {1'b0, den});
  assign diff         = trial[IN_W-1:0] - den;
  assign rem_out      = q_bit ? diff : trial[IN_W-1:0];
  assign q_out        = {q_in[Q_W-2:0], q_bit};
  assign unused_q_msb = q_in[Q_W-1];
endmodule

// File: rtl/barycentric_shade_pipe.sv
// Pipelined per-fragment shader: floor(num * 2^Q_W / den) per channel with
// saturation and background substitution, valid/ready with full-pipe stall.
module barycentric_shade_pipe
  import fs_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int Q_W  = Q_W_DEF,
  parameter int CH   = CH_DEF,
  parameter logic [CH*Q_W-1:0] BG_COLOR = BG_COLOR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_visible,
  input  logic [CH*IN_W-1:0]   in_num,
  input  logic [IN_W-1:0]      in_den,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*Q_W-1:0]    out_color
);
  logic stall;

  // Stage inputs: index 0 is the combinational capture, index k reads register rank k.
  logic [IN_W-1:0] st_rem [Q_W][CH];
  logic [Q_W-1:0]  st_q   [Q_W][CH];
  logic [IN_W-1:0] st_den [Q_W];
  logic            st_vis [Q_W];
  logic [CH-1:0]   st_sat [Q_W];
  logic [IN_W-1:0] nx_rem [Q_W][CH];
  logic [Q_W-1:0]  nx_q   [Q_W][CH];

  logic [Q_W-1:1]  vld_q;
  logic [Q_W-1:1]  vis_q;
  logic [IN_W-1:0] rem_q [1:Q_W-1][CH];
  logic [Q_W-1:0]  q_q   [1:Q_W-1][CH];
  logic [IN_W-1:0] den_q [1:Q_W-1];
  logic [CH-1:0]   sat_q [1:Q_W-1];

  logic              out_valid_q;
  logic [CH*Q_W-1:0] out_color_q;
  logic [CH*Q_W-1:0] out_color_d;
  logic              unused_last_rem;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_color = out_color_q;

  always_comb begin
    st_den[0] = in_den;
    st_vis[0] = in_visible;
    for (int c = 0; c < CH; c++) begin
      st_rem[0][c] = in_num[`FS_CH_SLICE(c, IN_W)];
      st_q[0][c]   = '0;
      st_sat[0][c] = (in_den == '0) || (in_num[`FS_CH_SLICE(c, IN_W)] >= in_den);
    end
    for (int k = 1; k < Q_W; k++) begin
      st_den[k] = den_q[k];
      st_vis[k] = vis_q[k];
      st_sat[k] = sat_q[k];
      for (int c = 0; c < CH; c++) begin
        st_rem[k][c] = rem_q[k][c];
        st_q[k][c]   = q_q[k][c];
      end
    end
  end

  for (genvar k = 0; k < Q_W; k++) begin : g_stage
    for (genvar c = 0; c < CH; c++) begin : g_ch
      bary_div_stage #(
        .IN_W(IN_W),
        .Q_W (Q_W)
      ) u_stage (
        .rem    (st_rem[k][c]),
        .den    (st_den[k]),
        .q_in   (st_q[k][c]),
        .rem_out(nx_rem[k][c]),
        .q_out  (nx_q[k][c])
      );
    end
  end

  always_comb begin
    unused_last_rem = 1'b0;
    for (int c = 0; c < CH; c++) begin
      unused_last_rem = unused_last_rem ^ (^nx_rem[Q_W-1][c]);
    end
  end

  always_comb begin
    out_color_d = BG_COLOR;
    if (st_vis[Q_W-1]) begin
      for (int c = 0; c < CH; c++) begin
        out_color_d[`FS_CH_SLICE(c, Q_W)] = st_sat[Q_W-1][c] ? {Q_W{1'b1}} : nx_q[Q_W-1][c];
      end
    end else begin
      out_color_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else if (!stall) begin
      vld_q[1] <= in_valid;
      for (int k = 2; k < Q_W; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      out_valid_q <= vld_q[Q_W-1];
      out_color_q <= out_color_d;
    end
  end

  // Payload ranks carry no reset; empty slots are qualified by vld_q.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 1; k < Q_W; k++) begin
        den_q[k] <= st_den[k-1];
        vis_q[k] <= st_vis[k-1];
        sat_q[k] <= st_sat[k-1];
        for (int c = 0; c < CH; c++) begin
          rem_q[k][c] <= nx_rem[k-1][c];
          q_q[k][c]   <= nx_q[k-1][c];
        end
      end
    end
  end
endmodule

// File: tb/tb_barycentric_shade_pipe.sv
// Self-checking bench: vector table plus random streams, checked through a
// scoreboard queue filled on input transfers and drained on output transfers.
module tb_barycentric_shade_pipe;
  localparam int Q_W = 4;
  localparam logic [11:0] BG = 12'h137;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_visible;
  logic [59:0] in_num;
  logic [19:0] in_den;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_color;

  always #5 clk = ~clk;

  barycentric_shade_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_visible(in_visible),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_color (out_color)
  );

  typedef struct {
    logic        vis;
    logic [59:0] num;
    logic [19:0] den;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [11:0] sb_q[$];
  logic [11:0] cur_exp;
  logic [11:0] prev_color = 12'h000;
  logic        prev_stall = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          run_len = 0;
  int          max_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] model(input logic vis, input logic [59:0] num, input logic [19:0] den);
    logic [11:0] r;
    logic [63:0] q;
    r = 12'h000;
    if (!vis) return BG;
    for (int c = 0; c < 3; c++) begin
      if (den == 20'd0 || num[c*20 +: 20] >= den) begin
        r[c*4 +: 4] = 4'hF;
      end else begin
        q = {40'd0, num[c*20 +: 20], 4'd0} / {44'd0, den};
        r[c*4 +: 4] = q[3:0];
      end
    end
    return r;
  endfunction

  // Scoreboard, handshake and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
      run_len = 0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_color", 32'(out_color), 32'(prev_color));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h required=none", out_color);
        end else begin
          check("color", 32'(out_color), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
      prev_stall = out_valid && !out_ready;
      prev_color = out_color;
      run_len = out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vis, input logic [59:0] num, input logic [19:0] den, input logic [11:0] e);
    in_valid   = 1'b1;
    in_visible = vis;
    in_num     = num;
    in_den     = den;
    cur_exp    = e;
  endtask

  task automatic rand_frag();
    logic [19:0] d;
    logic [59:0] n;
    logic        v;
    int          m;
    m = $urandom_range(0, 3);
    d = (m == 0) ? 20'd0 : (m == 1) ? 20'($urandom_range(1, 40)) : 20'($urandom_range(1, 20'hFFFFF));
    for (int c = 0; c < 3; c++) begin
      n[c*20 +: 20] = ($urandom % 4 == 0) ? 20'($urandom) : 20'($urandom_range(0, 32'(d)));
    end
    v = ($urandom % 8) != 0;
    drive(v, n, d, model(v, n, d));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(n >= 100), 32'd0);
  endtask

  task automatic latency_run(input string name, input vec_t v);
    int lat;
    drive(v.vis, v.num, v.den, v.exp);
    tick();
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(Q_W));
    check({name, "_color"}, 32'(out_color), 32'(v.exp));
    drain({name, "_drain"});
  endtask

  initial begin
    int sent;
    int cyc;
    int n;
    logic acc;

    vecs[0] = '{1'b1, {20'd0, 20'd1, 20'd1}, 20'd2, 12'h088};
    vecs[1] = '{1'b1, {20'd5, 20'd3, 20'd1}, 20'd16, 12'h531};
    vecs[2] = '{1'b1, {20'd5, 20'd3, 20'd1}, 20'd0, 12'hFFF};
    vecs[3] = '{1'b1, {20'd7, 20'd16, 20'd16}, 20'd16, 12'h7FF};
    vecs[4] = '{1'b0, {20'd1, 20'd2, 20'd3}, 20'd0, 12'h137};
    vecs[5] = '{1'b0, {20'd9, 20'd9, 20'd9}, 20'd5, 12'h137};
    vecs[6] = '{1'b1, {20'd2, 20'd1, 20'd0}, 20'd3, 12'hA50};
    vecs[7] = '{1'b1, {20'd0, 20'd11, 20'd9}, 20'd10, 12'h0FE};
    vecs[8] = '{1'b1, {20'hFFFFE, 20'h80000, 20'd0}, 20'hFFFFF, 12'hF80};

    rst = 1'b1;
    in_valid = 1'b0;
    in_visible = 1'b0;
    in_num = 60'd0;
    in_den = 20'd0;
    out_ready = 1'b1;
    cur_exp = 12'h000;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    latency_run("first", vecs[0]);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vis, vecs[i].num, vecs[i].den, vecs[i].exp);
      tick();
    end
    in_valid = 1'b0;
    drain("table_drain");

    // Back-to-back stream must come out as one unbroken run.
    max_run = 0;
    for (int i = 0; i < 20; i++) begin
      rand_frag();
      tick();
    end
    in_valid = 1'b0;
    drain("stream_drain");
    check("stream_run", 32'(max_run), 32'd20);

    sent = 0;
    cyc = 0;
    while (sent < 500 && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (!in_valid || acc) begin
        if (sent < 500 && ($urandom % 4) != 0) rand_frag();
        else in_valid = 1'b0;
      end
      out_ready = 1'($urandom % 2);
    end
    check("rand_sent", 32'(sent), 32'd500);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    // Reset with three fragments in flight flushes them all.
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i + 5].vis, vecs[i + 5].num, vecs[i + 5].den, vecs[i + 5].exp);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (out_valid) n++;
    end
    check("flush_quiet", 32'(n), 32'd0);
    latency_run("post_rst", vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
